memory_loader: RTL and testbench

- Loads a 4x4 feature matrix A and a 4x4 weight matrix W, each as a serial byte stream in row-major order.
- On start, computes C = A x W with 8-bit truncated results.
- Stores C in the upper half of the feature memory and presents each result byte on port_O.
- Sits between a byte-wide host loader and downstream logic that reads results from port_O or from the memory.

---
 rtl/memory_loader.sv | 115 +++++++++++
 tb/tb_memory_loader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_loader.sv
// Loads a feature matrix A and a weight matrix W as serial byte streams,
// then computes C = A x W (8-bit truncated) into the upper half of feature memory.
module memory_loader #(
    parameter int DW = 8,
    parameter int N  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] port_A,
    input  logic [DW-1:0] port_W,
    input  logic          write_enable_A,
    input  logic          write_enable_W,
    input  logic          startSignal,
    input  logic          clk2,
    output logic [DW-1:0] port_O
);

    localparam int NN = N * N;
    localparam int IW = $clog2(N);
    localparam int PW = $clog2(NN);
    localparam int AW = 2 * DW + $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, MAC, STORE, DONE} state_t;

    state_t state, state_next;

    logic [DW-1:0] Feature_Memory [2*NN];
    logic [DW-1:0] Weight_Memory  [NN];

    logic [PW-1:0] wptr_A, wptr_W;
    logic [IW-1:0] row_idx, col_idx, k_idx;
    logic [AW-1:0] acc;
    logic [AW-1:0] product;
    logic          start_ok;

    // clk2 exists only for pin compatibility with the older block.
    logic unused_clk2;
    assign unused_clk2 = clk2;

    assign start_ok = startSignal && !write_enable_A && !write_enable_W;

    // Widen before multiplying so the product is not truncated to DW bits.
    assign product = AW'(Feature_Memory[{1'b0, row_idx, k_idx}])
                   * AW'(Weight_Memory[{k_idx, col_idx}]);

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state always uses non-blocking assignment so every
        // register samples pre-edge values, independent of statement order.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: default first, so no path through the case leaves state_next
        // unassigned and infers a latch.
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = MAC;
            MAC:     if (k_idx == LAST) state_next = STORE;
            STORE:   state_next = (row_idx == LAST && col_idx == LAST) ? DONE : MAC;
            DONE:    if (!startSignal) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the memories are externally observable and must read zero
            // after reset, so they are cleared here rather than left as plain RAM.
            for (int i = 0; i < 2 * NN; i++) Feature_Memory[i] <= '0;
            for (int i = 0; i < NN; i++)     Weight_Memory[i]  <= '0;
            wptr_A  <= '0;
            wptr_W  <= '0;
            row_idx <= '0;
            col_idx <= '0;
            k_idx   <= '0;
            acc     <= '0;
            port_O  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (write_enable_W) begin
                        Weight_Memory[wptr_W] <= port_W;
                        wptr_W <= wptr_W + 1'b1;
                    end
                    // Loading addresses only the lower half; results are never clobbered.
                    if (write_enable_A) begin
                        Feature_Memory[{1'b0, wptr_A}] <= port_A;
                        wptr_A <= wptr_A + 1'b1;
                    end
                    if (start_ok) begin
                        row_idx <= '0;
                        col_idx <= '0;
                        k_idx   <= '0;
                        acc     <= '0;
                    end
                end
                MAC: begin
                    acc   <= acc + product;
                    k_idx <= k_idx + 1'b1;
                end
                STORE: begin
                    Feature_Memory[{1'b1, row_idx, col_idx}] <= acc[DW-1:0];
                    port_O  <= acc[DW-1:0];
                    acc     <= '0;
                    col_idx <= col_idx + 1'b1;
                    if (col_idx == LAST) row_idx <= row_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_loader.sv
// Self-checking bench for memory_loader: randomized loads checked against a
// matrix-level reference model of both memories and port_O.
module tb_memory_loader;

    logic       clk = 1'b0;
    logic       clk2 = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] port_A = '0;
    logic [7:0] port_W = '0;
    logic       write_enable_A = 1'b0;
    logic       write_enable_W = 1'b0;
    logic       startSignal = 1'b0;
    logic [7:0] port_O;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: memory images, write pointers, expected port_O.
    int m_fm [32];
    int m_wm [16];
    int m_wa, m_ww, m_port;

    memory_loader #(.DW(8), .N(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .port_A         (port_A),
        .port_W         (port_W),
        .write_enable_A (write_enable_A),
        .write_enable_W (write_enable_W),
        .startSignal    (startSignal),
        .clk2           (clk2),
        .port_O         (port_O)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) m_fm[i] = 0;
        for (int i = 0; i < 16; i++) m_wm[i] = 0;
        m_wa = 0;
        m_ww = 0;
        m_port = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
    endtask

    task automatic load_w(input logic [7:0] v);
        port_W = v;
        write_enable_W = 1'b1;
        @(posedge clk);
        #1;
        write_enable_W = 1'b0;
        m_wm[m_ww] = v;
        m_ww = (m_ww + 1) % 16;
    endtask

    task automatic load_a(input logic [7:0] v);
        port_A = v;
        write_enable_A = 1'b1;
        @(posedge clk);
        #1;
        write_enable_A = 1'b0;
        m_fm[m_wa] = v;
        m_wa = (m_wa + 1) % 16;
    endtask

    // C = A x W over the model's current A and W, truncated to 8 bits.
    task automatic model_compute();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                int sum = 0;
                for (int k = 0; k < 4; k++) sum += m_fm[4*r+k] * m_wm[4*k+c];
                m_fm[16+4*r+c] = sum % 256;
                m_port = sum % 256;
            end
    endtask

    task automatic load_random(input int lo, input int hi);
        for (int i = 0; i < 16; i++) load_w(8'($urandom_range(hi, lo)));
        for (int i = 0; i < 16; i++) load_a(8'($urandom_range(hi, lo)));
    endtask

    // Start, wait 1 accepting edge + 80 computing edges, release start.
    task automatic run_compute();
        startSignal = 1'b1;
        step(81);
        model_compute();
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 32; i++) begin
            n_total++;
            if (dut.Feature_Memory[i] !== 8'(m_fm[i]))
                $display("FAIL reset fm[%0d]: got %0d expected %0d", i, dut.Feature_Memory[i], m_fm[i]);
            else n_pass++;
        end
        for (int i = 0; i < 16; i++) begin
            n_total++;
            if (dut.Weight_Memory[i] !== 8'(m_wm[i]))
                $display("FAIL reset wm[%0d]: got %0d expected %0d", i, dut.Weight_Memory[i], m_wm[i]);
            else n_pass++;
        end
        n_total++;
        if (port_O !== 8'(m_port)) $display("FAIL reset port_O: got %0d expected %0d", port_O, m_port);
        else n_pass++;
    endtask

    task automatic test_load_multiply();
        logic [7:0] w_rows [16] = '{4,0,2,1, 4,3,2,0, 4,3,0,1, 4,3,2,1};
        logic [7:0] a_row  [4]  = '{1,2,3,4};
        bit bad;
        for (int i = 0; i < 16; i++) load_w(w_rows[i]);
        for (int i = 0; i < 16; i++) load_a(a_row[i%4]);
        startSignal = 1'b1;
        step(80);
        n_total++;
        if (port_O !== 8'd14) $display("FAIL timing_c32 port_O: got %0d expected 14", port_O);
        else n_pass++;
        step(1);
        model_compute();
        for (int i = 0; i < 32; i++) begin
            n_total++;
            if (dut.Feature_Memory[i] !== 8'(m_fm[i]))
                $display("FAIL mult fm[%0d]: got %0d expected %0d", i, dut.Feature_Memory[i], m_fm[i]);
            else n_pass++;
        end
        for (int i = 0; i < 16; i++) begin
            n_total++;
            if (dut.Weight_Memory[i] !== 8'(m_wm[i]))
                $display("FAIL mult wm[%0d]: got %0d expected %0d", i, dut.Weight_Memory[i], m_wm[i]);
            else n_pass++;
        end
        n_total++;
        if (port_O !== 8'(m_port)) $display("FAIL mult port_O: got %0d expected %0d", port_O, m_port);
        else n_pass++;
        // Start held high in DONE must not rerun: port_O would cycle away from C[3][3].
        bad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (port_O !== 8'(m_port)) bad = 1'b1;
        end
        n_total++;
        if (bad) $display("FAIL no_rerun port_O: got %0d expected %0d", port_O, m_port);
        else n_pass++;
        // Low-then-high pulse reruns: C[0][0] appears 5 edges after acceptance.
        startSignal = 1'b0;
        step(2);
        startSignal = 1'b1;
        step(6);
        n_total++;
        if (port_O !== 8'(m_fm[16])) $display("FAIL rerun port_O: got %0d expected %0d", port_O, m_fm[16]);
        else n_pass++;
        step(75);
        startSignal = 1'b0;
        step(1);
    endtask

    task automatic test_truncation();
        for (int i = 0; i < 16; i++) load_w(8'd255);
        for (int i = 0; i < 16; i++) load_a(8'd255);
        run_compute();
        startSignal = 1'b0;
        step(1);
        for (int i = 16; i < 32; i++) begin
            n_total++;
            if (dut.Feature_Memory[i] !== 8'(m_fm[i]))
                $display("FAIL trunc fm[%0d]: got %0d expected %0d", i, dut.Feature_Memory[i], m_fm[i]);
            else n_pass++;
        end
        n_total++;
        if (port_O !== 8'(m_port)) $display("FAIL trunc port_O: got %0d expected %0d", port_O, m_port);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            load_random(0, 255);
            run_compute();
            startSignal = 1'b0;
            step(1);
            for (int i = 0; i < 32; i++) begin
                n_total++;
                if (dut.Feature_Memory[i] !== 8'(m_fm[i]))
                    $display("FAIL rand%0d fm[%0d]: got %0d expected %0d", it, i, dut.Feature_Memory[i], m_fm[i]);
                else n_pass++;
            end
            for (int i = 0; i < 16; i++) begin
                n_total++;
                if (dut.Weight_Memory[i] !== 8'(m_wm[i]))
                    $display("FAIL rand%0d wm[%0d]: got %0d expected %0d", it, i, dut.Weight_Memory[i], m_wm[i]);
                else n_pass++;
            end
            n_total++;
            if (port_O !== 8'(m_port)) $display("FAIL rand%0d port_O: got %0d expected %0d", it, port_O, m_port);
            else n_pass++;
        end
    endtask

    task automatic test_pointer_wrap();
        apply_reset();
        for (int v = 1; v <= 17; v++) load_w(8'(v));
        for (int i = 0; i < 16; i++) begin
            n_total++;
            if (dut.Weight_Memory[i] !== 8'(m_wm[i]))
                $display("FAIL wrap wm[%0d]: got %0d expected %0d", i, dut.Weight_Memory[i], m_wm[i]);
            else n_pass++;
        end
    endtask

    task automatic test_start_gating();
        bit bad;
        apply_reset();
        // Small operands keep every C element nonzero, so an early start is visible.
        for (int i = 0; i < 16; i++) load_w(8'($urandom_range(3, 1)));
        for (int i = 0; i < 15; i++) load_a(8'($urandom_range(15, 1)));
        startSignal = 1'b1;
        for (int i = 0; i < 9; i++) load_a(8'($urandom_range(15, 1)));
        bad = 1'b0;
        for (int i = 16; i < 32; i++) if (dut.Feature_Memory[i] !== 8'd0) bad = 1'b1;
        n_total++;
        if (bad || port_O !== 8'd0)
            $display("FAIL gating early_start: got port_O %0d fm[16] %0d expected 0", port_O, dut.Feature_Memory[16]);
        else n_pass++;
        step(81);
        model_compute();
        for (int i = 0; i < 32; i++) begin
            n_total++;
            if (dut.Feature_Memory[i] !== 8'(m_fm[i]))
                $display("FAIL gating fm[%0d]: got %0d expected %0d", i, dut.Feature_Memory[i], m_fm[i]);
            else n_pass++;
        end
        n_total++;
        if (port_O !== 8'(m_port)) $display("FAIL gating port_O: got %0d expected %0d", port_O, m_port);
        else n_pass++;
        startSignal = 1'b0;
        step(1);
    endtask

    task automatic test_reset_mid();
        bit bad;
        apply_reset();
        load_random(1, 255);
        startSignal = 1'b1;
        step(30);
        rst = 1'b1;
        startSignal = 1'b0;
        #2;
        clear_model();
        bad = 1'b0;
        for (int i = 0; i < 32; i++) if (dut.Feature_Memory[i] !== 8'(m_fm[i])) bad = 1'b1;
        for (int i = 0; i < 16; i++) if (dut.Weight_Memory[i] !== 8'(m_wm[i])) bad = 1'b1;
        n_total++;
        if (bad) $display("FAIL mid_reset memory: got fm[0] %0d wm[0] %0d expected 0", dut.Feature_Memory[0], dut.Weight_Memory[0]);
        else n_pass++;
        n_total++;
        if (port_O !== 8'd0) $display("FAIL mid_reset port_O: got %0d expected 0", port_O);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(20);
        bad = 1'b0;
        for (int i = 16; i < 32; i++) if (dut.Feature_Memory[i] !== 8'd0) bad = 1'b1;
        n_total++;
        if (bad || port_O !== 8'd0)
            $display("FAIL mid_reset resumed: got port_O %0d fm[16] %0d expected 0", port_O, dut.Feature_Memory[16]);
        else n_pass++;
        // A load landing at entry 0 shows the FSM is back in IDLE with pointers cleared.
        load_w(8'h5A);
        n_total++;
        if (dut.Weight_Memory[0] !== 8'(m_wm[0]))
            $display("FAIL mid_reset idle_load: got %0d expected %0d", dut.Weight_Memory[0], m_wm[0]);
        else n_pass++;
    endtask

    initial begin
        clear_model();
        test_reset();
        test_load_multiply();
        test_truncation();
        test_random();
        test_pointer_wrap();
        test_start_gating();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
